// File: rtl/shift_seq_unit.sv
// Iterative shift/rotate unit: accepts one operand, moves it one bit per clock,
// and holds result/C/Z on a valid/ready response port until the consumer takes it.
module shift_seq_unit #(
    parameter int          WIDTH  = 8,
    parameter int          CNT_W  = $clog2(WIDTH),
    parameter logic [3:0]  SHL_FN = 4'h0,
    parameter logic [3:0]  SHR_FN = 4'h1,
    parameter logic [3:0]  ROL_FN = 4'h2,
    parameter logic [3:0]  ROR_FN = 4'h3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_opcode,
    input  logic [CNT_W-1:0] in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_c,
    output logic             out_z
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               c_q, c_d;
    logic [3:0]         op_q, op_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            c_q     <= 1'b0;
            op_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            c_q     <= c_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        c_d     = c_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    op_d    = in_opcode;
                    rem_d   = in_count;
                    c_d     = 1'b0;
                    state_d = (in_count != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // Unknown opcodes still burn the cycles but leave the operand and C alone.
                case (op_q)
                    SHL_FN: begin
                        c_d    = work_q[WIDTH-1];
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                    end
                    SHR_FN: begin
                        c_d    = work_q[0];
                        work_d = {1'b0, work_q[WIDTH-1:1]};
                    end
                    ROL_FN:  work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                    ROR_FN:  work_d = {work_q[0], work_q[WIDTH-1:1]};
                    default: work_d = work_q;
                endcase
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs decode directly from flops, so no in_* signal reaches an out_* combinationally.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = work_q;
    assign out_c     = c_q;
    assign out_z     = (work_q == '0);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Randomised and directed bench for shift_seq_unit against an arithmetic reference model.
module tb_shift_seq_unit;

    localparam int         W      = 8;
    localparam int         CW     = 3;
    localparam logic [3:0] SHL_FN = 4'h0;
    localparam logic [3:0] SHR_FN = 4'h1;
    localparam logic [3:0] ROL_FN = 4'h2;
    localparam logic [3:0] ROR_FN = 4'h3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_opcode;
    logic [CW-1:0] in_count;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_c;
    logic          out_z;

    int n_cmp;
    int n_bad;

    shift_seq_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_opcode(in_opcode),
        .in_count (in_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_c    (out_c),
        .out_z    (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {C, result}: whole-count shifts/rotates expressed with integer arithmetic.
    function automatic int ref_op(input logic [3:0] op, input int d, input int n);
        int res;
        int c;
        res = d;
        c   = 0;
        if (n != 0) begin
            case (op)
                SHL_FN: begin res = (d << n) & 255;                 c = (d >> (W - n)) & 1; end
                SHR_FN: begin res = d >> n;                         c = (d >> (n - 1)) & 1; end
                ROL_FN: begin res = ((d << n) | (d >> (W - n))) & 255; end
                ROR_FN: begin res = ((d >> n) | (d << (W - n))) & 255; end
                default: res = d;
            endcase
        end
        return (c << 8) | res;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [7:0] d, input int n, input int hold);
        int exp;
        int lat;
        int guard;
        exp   = ref_op(op, int'(d), n);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_ready", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_opcode = op;
        in_count  = CW'(n);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 40) begin
            chk("busy_ready", int'(in_ready), 0);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            in_opcode = 4'($urandom);
            in_count  = CW'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, n + 1);
        chk("data", int'(out_data), exp & 255);
        chk("carry", int'(out_c), (exp >> 8) & 1);
        chk("zero", int'(out_z), ((exp & 255) == 0) ? 1 : 0);
        chk("done_ready", int'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), exp & 255);
        chk("hold_carry", int'(out_c), (exp >> 8) & 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", int'(out_valid), 0);
        chk("post_ready", int'(in_ready), 1);
        $display("op=%0h data=%02h cnt=%0d -> out=%02h c=%0b z=%0b lat=%0d",
                 op, d, n, out_data, out_c, out_z, lat);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_c"}, int'(out_c), 0);
        chk({tag, "_out_z"}, int'(out_z), 1);
    endtask

    initial begin
        logic [3:0] op;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_opcode = SHL_FN;
        in_count  = 3'd3;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_rst");

        run_op(SHL_FN, 8'b1000_0001, 1, 0);
        run_op(SHR_FN, 8'h01, 1, 2);
        run_op(SHR_FN, 8'hF0, 7, 0);
        run_op(ROL_FN, 8'h81, 3, 1);
        run_op(ROR_FN, 8'h81, 1, 0);
        run_op(SHL_FN, 8'hA5, 0, 0);
        run_op(4'h9, 8'h3C, 5, 0);
        run_op(ROL_FN, 8'h5A, 7, 10);

        // Asynchronous reset in the middle of a long shift.
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_opcode = SHL_FN;
        in_count  = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("held_rst");
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        run_op(ROR_FN, 8'h01, 1, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: op = SHL_FN;
                1: op = SHR_FN;
                2: op = ROL_FN;
                3: op = ROR_FN;
                default: op = 4'($urandom_range(4, 15));
            endcase
            run_op(op, 8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
